// File: rtl/wb_sdram_arbiter_if.sv
// Bus bundle between NM Wishbone masters, the round-robin arbiter and the
// single Wishbone slave port of the SDRAM controller.
// The arbiter acts as the slave of the masters' bus, so it takes the "slave"
// modport. The environment (masters plus SDRAM side) takes the "master" modport.
interface wb_sdram_arbiter_if #(
  parameter int NM = 3,
  parameter int AW = 26,
  parameter int DW = 32
);
  logic [NM-1:0]        m_cyc_i;
  logic [NM-1:0]        m_stb_i;
  logic [NM-1:0]        m_we_i;
  logic [NM*AW-1:0]     m_addr_i;
  logic [NM*DW-1:0]     m_dat_i;
  logic [NM*DW/8-1:0]   m_sel_i;
  logic [NM*3-1:0]      m_cti_i;
  logic [NM-1:0]        m_ack_o;
  logic [NM-1:0]        m_err_o;
  logic [DW-1:0]        m_dat_o;
  logic                 s_cyc_o;
  logic                 s_stb_o;
  logic                 s_we_o;
  logic [AW-1:0]        s_addr_o;
  logic [DW-1:0]        s_dat_o;
  logic [DW/8-1:0]      s_sel_o;
  logic [2:0]           s_cti_o;
  logic                 s_ack_i;
  logic [DW-1:0]        s_dat_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    input  s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_dat_i, m_sel_i, m_cti_i,
    output s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o
  );
endinterface

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone arbiter letting NM masters share the single slave port
// of the SDRAM controller. A master keeps the bus for as long as it holds cyc
// (bursts and back-to-back singles), and every tenure ends with one RELEASE
// cycle in which the slave sees cyc/stb low.
// Optional ack watchdog: define WB_ARB_WATCHDOG_EN to abort a tenure with a
// one-cycle m_err_o pulse after TIMEOUT stalled strobe cycles.
module wb_sdram_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_resetn,
  wb_sdram_arbiter_if.slave     bus,
  output logic [NM-1:0]         grant_o,
  output logic                  busy_o
);

  localparam int PW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, BUS, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   gidx, gidx_nxt;
  logic [PW-1:0]   last_ptr, last_ptr_nxt;
  logic [NM-1:0]   grant_nxt;
  logic            req_found;
  logic [PW-1:0]   req_idx;
  logic [PW-1:0]   cand;
  logic            timeout_hit;

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0]     wd_cnt;

  // Count stalled strobe cycles of the current tenure; any ack restarts the count.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      wd_cnt <= '0;
    end else if (state != BUS || bus.s_ack_i) begin
      wd_cnt <= '0;
    end else if (bus.s_stb_o && wd_cnt != 16'(TIMEOUT)) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state == BUS) && (wd_cnt == 16'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  // Pick the first requester after the last owner, wrapping modulo NM.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NM; i++) begin
      cand = PW'((int'(last_ptr) + i) % NM);
      if (!req_found && bus.m_cyc_i[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
    end
  end

  // State, owner index, round-robin pointer and registered grant.
  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state    <= IDLE;
      gidx     <= '0;
      last_ptr <= PW'(NM - 1);
      grant_o  <= '0;
    end else begin
      state    <= state_nxt;
      gidx     <= gidx_nxt;
      last_ptr <= last_ptr_nxt;
      grant_o  <= grant_nxt;
    end
  end

  // Tenure sequencing plus per-master ack/err steering.
  always_comb begin
    state_nxt    = state;
    gidx_nxt     = gidx;
    last_ptr_nxt = last_ptr;
    grant_nxt    = grant_o;
    bus.m_ack_o  = '0;
    bus.m_err_o  = '0;
    case (state)
      IDLE: begin
        if (req_found) begin
          state_nxt          = BUS;
          gidx_nxt           = req_idx;
          grant_nxt          = '0;
          grant_nxt[req_idx] = 1'b1;
        end
      end
      BUS: begin
        if (timeout_hit) begin
          bus.m_err_o[gidx] = 1'b1;
          state_nxt         = RELEASE;
          last_ptr_nxt      = gidx;
          grant_nxt         = '0;
        end else begin
          bus.m_ack_o[gidx] = bus.s_ack_i;
          if (!bus.m_cyc_i[gidx]) begin
            state_nxt    = RELEASE;
            last_ptr_nxt = gidx;
            grant_nxt    = '0;
          end
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Route the owner's request to the slave; everything stays low outside BUS.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_addr_o = '0;
    bus.s_dat_o  = '0;
    bus.s_sel_o  = '0;
    bus.s_cti_o  = '0;
    if (state == BUS) begin
      bus.s_cyc_o  = bus.m_cyc_i[gidx];
      bus.s_stb_o  = bus.m_stb_i[gidx];
      bus.s_we_o   = bus.m_we_i[gidx];
      bus.s_addr_o = bus.m_addr_i[int'(gidx)*AW +: AW];
      bus.s_dat_o  = bus.m_dat_i[int'(gidx)*DW +: DW];
      bus.s_sel_o  = bus.m_sel_i[int'(gidx)*SW +: SW];
      bus.s_cti_o  = bus.m_cti_i[int'(gidx)*3 +: 3];
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign busy_o      = (state == BUS);

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: three master BFMs, a random-latency
// SDRAM slave model and a tenure-level round-robin reference model.
module tb_wb_sdram_arbiter;
  localparam int NM = 3;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NM-1:0] grant;
  logic busy;

  always #5 clk = ~clk;

  wb_sdram_arbiter_if #(.NM(NM), .AW(AW), .DW(DW)) bus ();

  wb_sdram_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(255)) dut (
    .wb_clk_i (clk),
    .wb_resetn(rst_n),
    .bus      (bus.slave),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  int checks = 0;
  int errors = 0;

  // Master BFM state
  bit          act[NM];
  bit          mstb[NM];
  bit          mwe[NM];
  int          maddr[NM];
  int          base[NM];
  int          nbeats[NM];
  int          beat[NM];
  int          reps[NM];
  logic [31:0] mdat[NM];
  logic [3:0]  msel[NM];
  logic [31:0] rd_last[NM];

  // Memories: ref_mem from the masters' view, slv_mem from the slave's view
  logic [31:0] ref_mem[int];
  logic [31:0] slv_mem[int];

  // Reference model of bus ownership
  int owner = -1;
  bit gap = 1'b0;
  int last = NM - 1;
  int dut_log[$];
  logic [NM-1:0] prev_grant = '0;

  // Samples and slave model
  logic [NM-1:0] ack_s;
  logic [31:0]   rdat_s;
  int            wait_cnt = 0;
  bit            ack_next;
  bit            stray_ack = 1'b0;
  logic [31:0]   rd_next;

  function automatic logic [31:0] memInit(int a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [31:0] refRead(int a);
    return ref_mem.exists(a) ? ref_mem[a] : memInit(a);
  endfunction

  function automatic int logCode();
    int code = 0;
    foreach (dut_log[i]) code = code * 10 + dut_log[i] + 1;
    return code;
  endfunction

  function automatic bit anyActive();
    for (int k = 0; k < NM; k++) if (act[k] || reps[k] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic driveMaster(input int k);
    bus.m_cyc_i[k] = act[k];
    bus.m_stb_i[k] = act[k] & mstb[k];
    bus.m_we_i[k]  = mwe[k];
    bus.m_addr_i[k*AW +: AW] = AW'(maddr[k]);
    bus.m_dat_i[k*DW +: DW]  = mdat[k];
    bus.m_sel_i[k*SW +: SW]  = msel[k];
    bus.m_cti_i[k*3 +: 3]    = (nbeats[k] == 1) ? 3'b000 :
                               (beat[k] == nbeats[k] - 1) ? 3'b111 : 3'b010;
  endtask

  task automatic applyStimulus(input int k, input bit we, input int addr, input int beats, input int nreps);
    act[k]    = 1'b1;
    mstb[k]   = 1'b1;
    mwe[k]    = we;
    maddr[k]  = addr;
    base[k]   = addr;
    nbeats[k] = beats;
    beat[k]   = 0;
    reps[k]   = nreps;
    mdat[k]   = $urandom;
    msel[k]   = 4'($urandom);
    driveMaster(k);
  endtask

  task automatic abortAll();
    for (int k = 0; k < NM; k++) begin
      act[k]  = 1'b0;
      reps[k] = 0;
      driveMaster(k);
    end
    bus.s_ack_i = 1'b0;
    wait_cnt    = 0;
  endtask

  // One clock: check at the falling edge, then drive at rising edge + 1
  task automatic stepCycle();
    logic [NM-1:0] exp_g;
    logic [NM-1:0] exp_ack;
    @(negedge clk);
    exp_g = '0;
    if (owner >= 0) exp_g[owner] = 1'b1;
    checkOutput("grant", grant, exp_g);
    checkOutput("busy", busy, owner >= 0);
    if (owner >= 0) begin
      checkOutput("s_cyc", bus.s_cyc_o, bus.m_cyc_i[owner]);
      checkOutput("s_stb", bus.s_stb_o, bus.m_stb_i[owner]);
      checkOutput("s_we", bus.s_we_o, bus.m_we_i[owner]);
      checkOutput("s_addr", bus.s_addr_o, bus.m_addr_i[owner*AW +: AW]);
      checkOutput("s_dat", bus.s_dat_o, bus.m_dat_i[owner*DW +: DW]);
      checkOutput("s_sel", bus.s_sel_o, bus.m_sel_i[owner*SW +: SW]);
      checkOutput("s_cti", bus.s_cti_o, bus.m_cti_i[owner*3 +: 3]);
    end else begin
      checkOutput("s_cyc_free", bus.s_cyc_o, 1'b0);
      checkOutput("s_stb_free", bus.s_stb_o, 1'b0);
    end
    exp_ack = '0;
    if (owner >= 0 && bus.s_ack_i) exp_ack[owner] = 1'b1;
    checkOutput("m_ack", bus.m_ack_o, exp_ack);
    checkOutput("m_err", bus.m_err_o, '0);
    checkOutput("m_dat", bus.m_dat_o, bus.s_dat_i);
    if (grant != '0 && prev_grant == '0)
      for (int i = 0; i < NM; i++) if (grant[i]) dut_log.push_back(i);
    prev_grant = grant;
    ack_s  = bus.m_ack_o;
    rdat_s = bus.m_dat_o;
    ack_next = 1'b0;
    rd_next  = '0;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (bus.s_ack_i) begin
      if (bus.s_cyc_o && bus.s_we_o) slv_mem[int'(bus.s_addr_o)] = bus.s_dat_o;
      wait_cnt = $urandom_range(0, 3);
    end else if (stray_ack) begin
      ack_next  = 1'b1;
      stray_ack = 1'b0;
    end else if (bus.s_cyc_o && bus.s_stb_o) begin
      if (wait_cnt == 0) begin
        ack_next = 1'b1;
        rd_next  = slv_mem.exists(int'(bus.s_addr_o)) ? slv_mem[int'(bus.s_addr_o)]
                                                      : memInit(int'(bus.s_addr_o));
      end else begin
        wait_cnt--;
      end
    end
    if (!rst_n) begin
      owner = -1; gap = 1'b0; last = NM - 1;
    end else if (owner >= 0) begin
      if (!bus.m_cyc_i[owner]) begin
        last = owner; owner = -1; gap = 1'b1;
      end
    end else if (gap) begin
      gap = 1'b0;
    end else begin
      for (int i = 1; i <= NM; i++)
        if (owner < 0 && bus.m_cyc_i[(last + i) % NM]) owner = (last + i) % NM;
    end
    @(posedge clk);
    #1;
    bus.s_ack_i = ack_next;
    bus.s_dat_i = ack_next ? rd_next : $urandom;
    for (int k = 0; k < NM; k++) begin
      if (act[k]) begin
        if (ack_s[k]) begin
          if (mwe[k]) begin
            ref_mem[maddr[k]] = mdat[k];
          end else begin
            rd_last[k] = rdat_s;
            checkOutput("rdata", rdat_s, refRead(maddr[k]));
          end
          beat[k]++;
          if (beat[k] == nbeats[k]) begin
            act[k] = 1'b0;
          end else begin
            maddr[k] += 4;
            mdat[k]  = $urandom;
            msel[k]  = 4'($urandom);
            mstb[k]  = ($urandom_range(0, 3) != 0);
          end
        end else begin
          mstb[k] = 1'b1;
        end
      end else if (reps[k] > 0) begin
        applyStimulus(k, mwe[k], base[k], nbeats[k], reps[k] - 1);
      end
      driveMaster(k);
    end
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    do begin
      stepCycle();
      n++;
    end while ((anyActive() || owner >= 0 || gap) && n < budget);
    checkOutput("idle_budget", n < budget, 1'b1);
    stepCycle();
    stepCycle();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    owner = -1; gap = 1'b0; last = NM - 1;
    abortAll();
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_addr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_cti_i = '0;
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    for (int k = 0; k < NM; k++) begin
      act[k] = 1'b0; reps[k] = 0; nbeats[k] = 1; beat[k] = 0; rd_last[k] = '0;
    end

    $display("[TB] reset state");
    repeat (3) stepCycle();
    checkOutput("reset_grant", grant, '0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_s_cyc", bus.s_cyc_o, 1'b0);
    checkOutput("reset_m_ack", bus.m_ack_o, '0);
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] single write/read by master 1");
    applyStimulus(1, 1'b1, 'h40, 1, 0);
    mdat[1] = 32'hDEAD_BEEF;
    driveMaster(1);
    runUntilIdle(200);
    applyStimulus(1, 1'b0, 'h40, 1, 0);
    runUntilIdle(200);
    checkOutput("readback", rd_last[1], 32'hDEAD_BEEF);
    checkOutput("sdram_word", slv_mem['h40], 32'hDEAD_BEEF);

    $display("[TB] simultaneous requests out of reset");
    pulseReset();
    dut_log.delete();
    applyStimulus(0, 1'b0, 'h80, 1, 0);
    applyStimulus(1, 1'b0, 'h84, 1, 0);
    applyStimulus(2, 1'b0, 'h88, 1, 0);
    runUntilIdle(300);
    checkOutput("order_012", logCode(), 123);

    $display("[TB] burst by master 0 with master 2 waiting");
    dut_log.delete();
    applyStimulus(0, 1'b1, 'h100, 4, 0);
    applyStimulus(2, 1'b0, 'h100, 1, 0);
    runUntilIdle(300);
    checkOutput("order_burst", logCode(), 13);

    $display("[TB] round-robin fairness on re-request");
    dut_log.delete();
    applyStimulus(0, 1'b0, 'h200, 2, 1);
    applyStimulus(1, 1'b1, 'h300, 1, 0);
    runUntilIdle(300);
    checkOutput("order_fair", logCode(), 121);

    $display("[TB] reset in the middle of a burst");
    applyStimulus(2, 1'b1, 'h400, 4, 0);
    n = 0;
    while (beat[2] < 2 && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("burst_budget", n < 200, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_s_cyc", bus.s_cyc_o, 1'b0);
    checkOutput("async_grant", grant, '0);
    checkOutput("async_m_ack", bus.m_ack_o, '0);
    checkOutput("async_busy", busy, 1'b0);
    owner = -1; gap = 1'b0; last = NM - 1;
    abortAll();
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
    dut_log.delete();
    applyStimulus(2, 1'b1, 'h400, 4, 0);
    applyStimulus(0, 1'b0, 'h400, 1, 0);
    runUntilIdle(300);
    checkOutput("order_after_reset", logCode(), 13);

    $display("[TB] stray slave ack while free");
    stray_ack = 1'b1;
    repeat (3) stepCycle();

    $display("[TB] random traffic");
    for (int r = 0; r < 60; r++) begin
      for (int k = 0; k < NM; k++)
        if (!act[k] && reps[k] == 0 && $urandom_range(0, 1) == 1)
          applyStimulus(k, 1'($urandom), 'h800 + 4 * $urandom_range(0, 15),
                        $urandom_range(1, 4), $urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) stepCycle();
    end
    runUntilIdle(3000);

    foreach (ref_mem[a])
      checkOutput("mem", slv_mem.exists(a) ? slv_mem[a] : memInit(a), ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
